ddr_rr_burst_arbiter: RTL and testbench
=======================================

Name: ddr_rr_burst_arbiter

Overview:
Round-robin arbiter that shares the single external DDR4 read and write channels among NUM_CORES solver cores. It sits between the per-core global_read/global_write ports and the satswarm_top DDR master pins. The read and write channels are arbitrated independently. Read bursts are owned end-to-end by one core, with beat counting and a stall watchdog. Writes are single-beat.

Parameters:
NUM_CORES, 4, number of requesting cores (>=1)
IDX_W, $clog2(NUM_CORES) (min 1), width of owner/pointer indices
TIMEOUT_CYCLES, 1024, max cycles between read beats in R_DATA before abort (0 disables the watchdog)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_read_req  in  NUM_CORES  per-core read request; held high until grant
core_read_addr  in  NUM_CORES*32  per-core byte address, core i at [32i+:32]
core_read_len  in  NUM_CORES*8  per-core burst length; beats = len+1
core_read_grant  out  NUM_CORES  one-hot grant pulse
core_read_data  out  32  read data, broadcast to all cores
core_read_valid  out  NUM_CORES  one-hot beat valid for the owner core
core_write_req  in  NUM_CORES  per-core write request
core_write_addr  in  NUM_CORES*32  per-core write address
core_write_data  in  NUM_CORES*32  per-core write data
core_write_grant  out  NUM_CORES  one-hot write accept pulse
ddr_read_req  out  1  DDR read request
ddr_read_addr  out  32  latched read address
ddr_read_len  out  8  latched read length
ddr_read_grant  in  1  DDR accepts read request
ddr_read_data  in  32  DDR read data
ddr_read_valid  in  1  DDR read beat valid
ddr_write_req  out  1  DDR write request
ddr_write_addr  out  32  latched write address
ddr_write_data  out  32  latched write data
ddr_write_grant  in  1  DDR accepts write
rd_busy  out  1  read FSM not in R_IDLE
rd_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all registered outputs 0, both FSMs idle, rd_ptr=wr_ptr=0, beat counter 0, watchdog 0.
- Read FSM states: R_IDLE -> R_REQ -> R_DATA -> R_IDLE.
- R_IDLE: if any core_read_req is high, select the first requester searching from rd_ptr upward with wrap. Latch owner, addr and len into registers. Go to R_REQ. ddr_read_req rises the next cycle (one-cycle arbitration latency).
- R_REQ: ddr_read_req=1 with the latched addr/len. On ddr_read_grant: core_read_grant[owner]=1 combinationally that cycle, load beats_left=len+1 (9-bit), go to R_DATA. ddr_read_req drops the next cycle.
- R_DATA: core_read_data=ddr_read_data at all times (combinational). core_read_valid[owner]=ddr_read_valid. Each valid decrements beats_left. On the last beat (beats_left==1 and valid): go to R_IDLE, rd_ptr=owner+1 mod NUM_CORES.
- len=255 gives 256 beats; the counter must not overflow.
- Watchdog: counts cycles in R_DATA since the last beat and resets on each beat. When it reaches TIMEOUT_CYCLES: pulse rd_timeout, go to R_IDLE, advance rd_ptr. Late beats after abort are dropped.
- ddr_read_valid while in R_IDLE or R_REQ: ignored, no core_read_valid asserted.
- A requester that drops core_read_req after selection does not cancel the transfer; the latched request completes.
- Back-to-back: from R_IDLE the next selection uses the updated rd_ptr, so no core is served twice while another waits.
- Write FSM states: W_IDLE -> W_REQ -> W_IDLE.
- W_IDLE: round-robin select from wr_ptr. Latch addr/data/owner into ddr_write_*. ddr_write_req=1 the next cycle.
- W_REQ: on ddr_write_grant, core_write_grant[owner]=1 that cycle, wr_ptr=owner+1, return to W_IDLE. Minimum two cycles per write.
- Read and write proceed concurrently; a simultaneous read and write from the same core are both legal.
- Grants are always one-hot or zero. Grant to a core whose req is low is illegal (assertion).
- Reset mid-burst: immediate idle, all outputs 0; outstanding DDR beats after reset are ignored.
- NUM_CORES=1: pointer is constant 0 and behaviour is otherwise identical.

Test Plan:
- Single read, core2 addr=0x4000_0010 len=3, grant 2 cycles after req -> ddr_read_addr=0x4000_0010, ddr_read_len=3, core_read_grant=0b0100 for one cycle, exactly 4 core_read_valid[2] pulses, rd_busy low after the 4th beat.
- All 4 cores request reads continuously with len=0 -> grant order 0,1,2,3,0,... with no core granted twice in any window of 4.
- Watchdog with TIMEOUT_CYCLES=16, core1 len=7, DDR sends 2 beats then stalls -> rd_timeout pulses 16 cycles after the 2nd beat, FSM returns to idle, a later beat produces no core_read_valid.
- Concurrency: core0 read len=255 while cores1/3 write 0xDEADBEEF/0x12345678 -> 256 valid beats to core0; writes granted order 1 then 3 with correct ddr_write_addr/data.
- Stray ddr_read_valid in R_IDLE -> all core_read_valid stay 0.
- rst_n low mid-burst (beat 5 of 8) -> async clear of ddr_read_req, rd_busy and grants; after release, a new request from core3 is served with rd_ptr=0 scan order.

Source files
------------

// File: rtl/ddr_rr_burst_arbiter.sv
// rtl/ddr_rr_burst_arbiter.sv - round-robin DDR read/write channel arbiter for NUM_CORES solver cores
// Reads own the channel for a whole burst with a stall watchdog; writes are single-beat.
module ddr_rr_burst_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CORES-1:0]     core_read_req,
   input  logic [NUM_CORES*32-1:0]  core_read_addr,
   input  logic [NUM_CORES*8-1:0]   core_read_len,
   output logic [NUM_CORES-1:0]     core_read_grant,
   output logic [31:0]              core_read_data,
   output logic [NUM_CORES-1:0]     core_read_valid,
   input  logic [NUM_CORES-1:0]     core_write_req,
   input  logic [NUM_CORES*32-1:0]  core_write_addr,
   input  logic [NUM_CORES*32-1:0]  core_write_data,
   output logic [NUM_CORES-1:0]     core_write_grant,
   output logic                     ddr_read_req,
   output logic [31:0]              ddr_read_addr,
   output logic [7:0]               ddr_read_len,
   input  logic                     ddr_read_grant,
   input  logic [31:0]              ddr_read_data,
   input  logic                     ddr_read_valid,
   output logic                     ddr_write_req,
   output logic [31:0]              ddr_write_addr,
   output logic [31:0]              ddr_write_data,
   input  logic                     ddr_write_grant,
   output logic                     rd_busy,
   output logic                     rd_timeout
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
   typedef enum logic       {W_IDLE, W_REQ} wr_state_t;

   // Returns {found, index}; scanning backwards lets the lowest offset from ptr win.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0] res;
      int idx;
      res = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_CORES;
         if (req[idx]) res = {1'b1, IDX_W'(idx)};
      end
      return res;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
      if (int'(cur) >= NUM_CORES - 1) return '0;
      return cur + 1'b1;
   endfunction

   rd_state_t        rd_state, rd_next;
   wr_state_t        wr_state, wr_next;
   logic [IDX_W-1:0] rd_owner, rd_ptr, wr_owner, wr_ptr;
   logic [IDX_W:0]   rd_pick, wr_pick;
   logic [8:0]       beats_left;
   logic [WD_W-1:0]  wdog;
   logic             rd_last;

   assign rd_pick        = rr_pick(core_read_req, rd_ptr);
   assign wr_pick        = rr_pick(core_write_req, wr_ptr);
   assign core_read_data = ddr_read_data;
   assign ddr_read_req   = (rd_state == R_REQ);
   assign ddr_write_req  = (wr_state == W_REQ);
   assign rd_busy        = (rd_state != R_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
      end else begin
         rd_state <= rd_next;
         wr_state <= wr_next;
      end
   end

   always_comb begin
      rd_next         = rd_state;
      core_read_grant = '0;
      core_read_valid = '0;
      rd_timeout      = 1'b0;
      rd_last         = 1'b0;
      case (rd_state)
         R_IDLE: if (rd_pick[IDX_W]) rd_next = R_REQ;
         R_REQ: begin
            if (ddr_read_grant) begin
               core_read_grant[rd_owner] = 1'b1;
               rd_next = R_DATA;
            end
         end
         R_DATA: begin
            core_read_valid[rd_owner] = ddr_read_valid;
            if (ddr_read_valid && beats_left == 9'd1) begin
               rd_last = 1'b1;
               rd_next = R_IDLE;
            end else if (!ddr_read_valid && TIMEOUT_CYCLES != 0 && wdog == WD_LAST) begin
               rd_timeout = 1'b1;
               rd_next    = R_IDLE;
            end
         end
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      wr_next          = wr_state;
      core_write_grant = '0;
      case (wr_state)
         W_IDLE: if (wr_pick[IDX_W]) wr_next = W_REQ;
         W_REQ: begin
            if (ddr_write_grant) begin
               core_write_grant[wr_owner] = 1'b1;
               wr_next = W_IDLE;
            end
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // 9-bit beat counter so len=255 (256 beats) loads without overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_owner      <= '0;
         rd_ptr        <= '0;
         ddr_read_addr <= '0;
         ddr_read_len  <= '0;
         beats_left    <= '0;
         wdog          <= '0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (rd_pick[IDX_W]) begin
                  rd_owner      <= rd_pick[IDX_W-1:0];
                  ddr_read_addr <= core_read_addr[rd_pick[IDX_W-1:0]*32 +: 32];
                  ddr_read_len  <= core_read_len[rd_pick[IDX_W-1:0]*8 +: 8];
               end
            end
            R_REQ: begin
               if (ddr_read_grant) begin
                  beats_left <= {1'b0, ddr_read_len} + 9'd1;
                  wdog       <= '0;
               end
            end
            R_DATA: begin
               if (ddr_read_valid) begin
                  beats_left <= beats_left - 9'd1;
                  wdog       <= '0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
               if (rd_last || rd_timeout) rd_ptr <= next_idx(rd_owner);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_owner       <= '0;
         wr_ptr         <= '0;
         ddr_write_addr <= '0;
         ddr_write_data <= '0;
      end else begin
         if (wr_state == W_IDLE && wr_pick[IDX_W]) begin
            wr_owner       <= wr_pick[IDX_W-1:0];
            ddr_write_addr <= core_write_addr[wr_pick[IDX_W-1:0]*32 +: 32];
            ddr_write_data <= core_write_data[wr_pick[IDX_W-1:0]*32 +: 32];
         end
         if (wr_state == W_REQ && ddr_write_grant) wr_ptr <= next_idx(wr_owner);
      end
   end

   a_rd_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(core_read_grant));
   a_rd_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(core_read_valid));
   a_wr_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(core_write_grant));
   a_wr_grant_req:    assert property (@(posedge clk) disable iff (!rst_n)
                                       (core_write_grant != '0) |-> ((core_write_grant & core_write_req) != '0));

endmodule

// File: tb/tb_ddr_rr_burst_arbiter.sv
// tb/tb_ddr_rr_burst_arbiter.sv - table-driven, scoreboard-checked bench for ddr_rr_burst_arbiter
module tb_ddr_rr_burst_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    core_read_req = '0;
   logic [N*32-1:0] core_read_addr = '0;
   logic [N*8-1:0]  core_read_len = '0;
   logic [N-1:0]    core_read_grant;
   logic [31:0]     core_read_data;
   logic [N-1:0]    core_read_valid;
   logic [N-1:0]    core_write_req = '0;
   logic [N*32-1:0] core_write_addr = '0;
   logic [N*32-1:0] core_write_data = '0;
   logic [N-1:0]    core_write_grant;
   logic            ddr_read_req;
   logic [31:0]     ddr_read_addr;
   logic [7:0]      ddr_read_len;
   logic            ddr_read_grant = 1'b0;
   logic [31:0]     ddr_read_data = '0;
   logic            ddr_read_valid = 1'b0;
   logic            ddr_write_req;
   logic [31:0]     ddr_write_addr;
   logic [31:0]     ddr_write_data;
   logic            ddr_write_grant = 1'b0;
   logic            rd_busy;
   logic            rd_timeout;

   always #5 clk = ~clk;

   ddr_rr_burst_arbiter #(.NUM_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_read_req(core_read_req), .core_read_addr(core_read_addr), .core_read_len(core_read_len),
      .core_read_grant(core_read_grant), .core_read_data(core_read_data), .core_read_valid(core_read_valid),
      .core_write_req(core_write_req), .core_write_addr(core_write_addr), .core_write_data(core_write_data),
      .core_write_grant(core_write_grant),
      .ddr_read_req(ddr_read_req), .ddr_read_addr(ddr_read_addr), .ddr_read_len(ddr_read_len),
      .ddr_read_grant(ddr_read_grant), .ddr_read_data(ddr_read_data), .ddr_read_valid(ddr_read_valid),
      .ddr_write_req(ddr_write_req), .ddr_write_addr(ddr_write_addr), .ddr_write_data(ddr_write_data),
      .ddr_write_grant(ddr_write_grant), .rd_busy(rd_busy), .rd_timeout(rd_timeout)
   );

   typedef struct { int core; logic [31:0] data; } beat_t;
   typedef struct { int core; logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct {
      int core; logic [31:0] addr; logic [7:0] len; int gdly;
      logic [3:0] exp_grant; logic [31:0] exp_addr; logic [7:0] exp_len; int exp_beats;
   } rd_vec_t;

   beat_t      rd_q[$];
   wr_t        wr_q[$];
   int         gnt_log[$];
   int         vcnt[N];
   logic [3:0] gnt_or;
   int         gnt_cycles;
   int         n_checks = 0;
   int         n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push_rd(input int c, input logic [31:0] a, input int nbeats);
      beat_t b;
      for (int k = 0; k < nbeats; k++) begin
         b.core = c;
         b.data = a + 32'(4 * k);
         rd_q.push_back(b);
      end
   endtask

   task automatic monitor();
      beat_t b;
      wr_t   w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (core_read_valid != '0) begin
               if (rd_q.size() == 0) chk("rd_stray_valid", 64'(core_read_valid), 0);
               else begin
                  b = rd_q.pop_front();
                  chk("rd_valid_owner", 64'(core_read_valid), 64'(4'b0001 << b.core));
                  chk("rd_data", 64'(core_read_data), 64'(b.data));
               end
               for (int c = 0; c < N; c++) if (core_read_valid[c]) vcnt[c]++;
            end
            if (core_read_grant != '0) begin
               chk("rd_grant_onehot", 64'($onehot(core_read_grant)), 1);
               gnt_or |= core_read_grant;
               gnt_cycles++;
               for (int c = 0; c < N; c++) if (core_read_grant[c]) gnt_log.push_back(c);
            end
            if (core_write_grant != '0) begin
               if (wr_q.size() == 0) chk("wr_stray_grant", 64'(core_write_grant), 0);
               else begin
                  w = wr_q.pop_front();
                  chk("wr_owner", 64'(core_write_grant), 64'(4'b0001 << w.core));
                  chk("wr_addr", 64'(ddr_write_addr), 64'(w.addr));
                  chk("wr_data", 64'(ddr_write_data), 64'(w.data));
               end
            end
         end
      end
   endtask

   task automatic ddr_write_model();
      forever begin
         @(posedge clk); #1;
         ddr_write_grant = rst_n && ddr_write_req && ($urandom_range(0, 2) == 0);
      end
   endtask

   task automatic rd_request(input int c, input logic [31:0] a, input logic [7:0] l);
      bit got = 0;
      core_read_addr[c*32 +: 32] = a;
      core_read_len[c*8 +: 8]    = l;
      core_read_req[c]           = 1'b1;
      for (int n = 0; n < 600 && !got; n++) begin
         @(negedge clk);
         if (core_read_grant[c]) got = 1;
      end
      if (!got) chk("rd_grant_wait", 0, 1);
      @(posedge clk); #1;
      core_read_req[c] = 1'b0;
   endtask

   task automatic do_write(input int c, input logic [31:0] a, input logic [31:0] d);
      bit got = 0;
      core_write_addr[c*32 +: 32] = a;
      core_write_data[c*32 +: 32] = d;
      core_write_req[c]           = 1'b1;
      for (int n = 0; n < 600 && !got; n++) begin
         @(negedge clk);
         if (core_write_grant[c]) got = 1;
      end
      if (!got) chk("wr_grant_wait", 0, 1);
      @(posedge clk); #1;
      core_write_req[c] = 1'b0;
   endtask

   // DDR read side: wait for the request, grant after gdly cycles, stream nsend beats of addr+4k.
   task automatic ddr_serve(input int gdly, input int nsend, output logic [31:0] a, output logic [7:0] l);
      int n = 0;
      a = '0;
      l = '0;
      while (!ddr_read_req && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ddr_read_req) begin
         chk("ddr_read_req_wait", 0, 1);
         return;
      end
      a = ddr_read_addr;
      l = ddr_read_len;
      repeat (gdly) begin @(posedge clk); #1; end
      ddr_read_grant = 1'b1;
      @(posedge clk); #1;
      ddr_read_grant = 1'b0;
      for (int k = 0; k < nsend; k++) begin
         ddr_read_valid = 1'b1;
         ddr_read_data  = a + 32'(4 * k);
         @(posedge clk); #1;
         ddr_read_valid = 1'b0;
      end
   endtask

   rd_vec_t     vecs[4];
   logic [31:0] ca;
   logic [7:0]  cl;
   int          wd_n;

   initial begin
      vecs[0] = '{core:2, addr:32'h4000_0010, len:8'd3, gdly:2, exp_grant:4'b0100,
                  exp_addr:32'h4000_0010, exp_len:8'd3, exp_beats:4};
      vecs[1] = '{core:0, addr:32'h1000_0000, len:8'd0, gdly:0, exp_grant:4'b0001,
                  exp_addr:32'h1000_0000, exp_len:8'd0, exp_beats:1};
      vecs[2] = '{core:1, addr:32'h3000_0008, len:8'd1, gdly:3, exp_grant:4'b0010,
                  exp_addr:32'h3000_0008, exp_len:8'd1, exp_beats:2};
      vecs[3] = '{core:3, addr:32'h2000_0100, len:8'd7, gdly:1, exp_grant:4'b1000,
                  exp_addr:32'h2000_0100, exp_len:8'd7, exp_beats:8};
      foreach (vcnt[i]) vcnt[i] = 0;
      gnt_or = '0;
      gnt_cycles = 0;
      fork
         monitor();
         ddr_write_model();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ddr_read_req", 64'(ddr_read_req), 0);
      chk("rst_ddr_write_req", 64'(ddr_write_req), 0);
      chk("rst_rd_busy", 64'(rd_busy), 0);
      chk("rst_ddr_read_addr", 64'(ddr_read_addr), 0);
      chk("rst_ddr_read_len", 64'(ddr_read_len), 0);
      chk("rst_ddr_write_addr", 64'(ddr_write_addr), 0);
      chk("rst_ddr_write_data", 64'(ddr_write_data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         @(posedge clk); #1;
         foreach (vcnt[i]) vcnt[i] = 0;
         gnt_or = '0;
         gnt_cycles = 0;
         push_rd(vecs[v].core, vecs[v].addr, int'(vecs[v].len) + 1);
         fork
            rd_request(vecs[v].core, vecs[v].addr, vecs[v].len);
            ddr_serve(vecs[v].gdly, int'(vecs[v].len) + 1, ca, cl);
         join
         @(negedge clk);
         chk("vec_ddr_read_addr", 64'(ca), 64'(vecs[v].exp_addr));
         chk("vec_ddr_read_len", 64'(cl), 64'(vecs[v].exp_len));
         chk("vec_grant", 64'(gnt_or), 64'(vecs[v].exp_grant));
         chk("vec_grant_cycles", 64'(gnt_cycles), 1);
         chk("vec_beats", 64'(vcnt[vecs[v].core]), 64'(vecs[v].exp_beats));
         chk("vec_busy_after", 64'(rd_busy), 0);
         chk("vec_sb_empty", 64'(rd_q.size()), 0);
      end

      @(posedge clk); #1;
      gnt_log.delete();
      foreach (vcnt[i]) vcnt[i] = 0;
      for (int c = 0; c < N; c++) begin
         core_read_addr[c*32 +: 32] = 32'h5000_0000 + 32'(c * 256);
         core_read_len[c*8 +: 8]    = 8'd0;
      end
      for (int r = 0; r < 8; r++) push_rd(r % N, 32'h5000_0000 + 32'((r % N) * 256), 1);
      core_read_req = '1;
      for (int r = 0; r < 8; r++) ddr_serve(0, 1, ca, cl);
      core_read_req = '0;
      chk("rr_grant_count", 64'(gnt_log.size()), 8);
      for (int i = 0; i < gnt_log.size(); i++) chk("rr_grant_order", 64'(gnt_log[i]), 64'(i % N));
      for (int c = 0; c < N; c++) chk("rr_beats_per_core", 64'(vcnt[c]), 2);

      @(posedge clk); #1;
      ddr_read_valid = 1'b1;
      ddr_read_data  = 32'hBAD0_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_idle_valid", 64'(core_read_valid), 0);
         @(posedge clk); #1;
      end
      ddr_read_valid = 1'b0;
      push_rd(0, 32'h6000_0000, 1);
      fork
         rd_request(0, 32'h6000_0000, 8'd0);
         begin
            for (int n = 0; n < 50 && !ddr_read_req; n++) begin @(posedge clk); #1; end
            ddr_read_valid = 1'b1;
            @(negedge clk);
            chk("stray_req_valid", 64'(core_read_valid), 0);
            chk("stray_req_busy", 64'(rd_busy), 1);
            @(posedge clk); #1;
            ddr_read_valid = 1'b0;
            ddr_serve(0, 1, ca, cl);
         end
      join
      chk("stray_sb_empty", 64'(rd_q.size()), 0);

      @(posedge clk); #1;
      foreach (vcnt[i]) vcnt[i] = 0;
      push_rd(1, 32'h7000_0000, 2);
      fork
         rd_request(1, 32'h7000_0000, 8'd7);
         ddr_serve(0, 2, ca, cl);
      join
      wd_n = 0;
      for (int n = 1; n <= 40 && wd_n == 0; n++) begin
         @(negedge clk);
         if (rd_timeout) wd_n = n;
      end
      chk("wd_latency", 64'(wd_n), 16);
      @(posedge clk); #1;
      chk("wd_idle_after", 64'(rd_busy), 0);
      chk("wd_pulse_width", 64'(rd_timeout), 0);
      ddr_read_valid = 1'b1;
      ddr_read_data  = 32'h1A7E_0000;
      @(negedge clk);
      chk("wd_late_beat", 64'(core_read_valid), 0);
      @(posedge clk); #1;
      ddr_read_valid = 1'b0;
      chk("wd_beats", 64'(vcnt[1]), 2);

      @(posedge clk); #1;
      foreach (vcnt[i]) vcnt[i] = 0;
      push_rd(2, 32'h8000_0000, 5);
      fork
         rd_request(2, 32'h8000_0000, 8'd7);
         ddr_serve(0, 5, ca, cl);
      join
      chk("rst_mid_beats", 64'(vcnt[2]), 5);
      ddr_read_valid = 1'b1;
      ddr_read_data  = 32'hDEAD_0006;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(rd_busy), 0);
      chk("rst_mid_ddr_req", 64'(ddr_read_req), 0);
      chk("rst_mid_grant", 64'(core_read_grant), 0);
      chk("rst_mid_valid", 64'(core_read_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_post_valid", 64'(core_read_valid), 0);
      @(posedge clk); #1;
      ddr_read_valid = 1'b0;
      chk("rst_post_sb_empty", 64'(rd_q.size()), 0);

      gnt_log.delete();
      push_rd(1, 32'hC000_0010, 1);
      push_rd(3, 32'hC000_0030, 1);
      fork
         rd_request(1, 32'hC000_0010, 8'd0);
         rd_request(3, 32'hC000_0030, 8'd0);
         begin
            ddr_serve(0, 1, ca, cl);
            ddr_serve(0, 1, ca, cl);
         end
      join
      chk("rst_ptr_count", 64'(gnt_log.size()), 2);
      chk("rst_ptr_first", (gnt_log.size() > 0) ? 64'(gnt_log[0]) : 64'hFF, 1);
      chk("rst_ptr_second", (gnt_log.size() > 1) ? 64'(gnt_log[1]) : 64'hFF, 3);

      @(posedge clk); #1;
      foreach (vcnt[i]) vcnt[i] = 0;
      push_rd(0, 32'h9000_0000, 256);
      wr_q.push_back('{core:1, addr:32'hA000_0004, data:32'hDEAD_BEEF});
      wr_q.push_back('{core:3, addr:32'hB000_000C, data:32'h1234_5678});
      fork
         rd_request(0, 32'h9000_0000, 8'd255);
         ddr_serve(1, 256, ca, cl);
         do_write(1, 32'hA000_0004, 32'hDEAD_BEEF);
         do_write(3, 32'hB000_000C, 32'h1234_5678);
      join
      @(negedge clk);
      chk("conc_len", 64'(cl), 255);
      chk("conc_beats", 64'(vcnt[0]), 256);
      chk("conc_rd_sb_empty", 64'(rd_q.size()), 0);
      chk("conc_wr_sb_empty", 64'(wr_q.size()), 0);
      chk("conc_busy_after", 64'(rd_busy), 0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
